gates_sweep_checker: RTL and testbench

//  Synthesisable self-checker for the simple-gates datapath.
//  Per channel c: led[2c+1] = AND of the upper GRP_W switch bits; led[2c] = OR of the lower GRP_W bits.

---
 rtl/gates_sweep_checker.sv | 212 +++++++++++++++++++++
 tb/tb_gates_sweep_checker.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gates_sweep_checker.sv
// Self-checker for the simple-gates datapath: scores a DUT over a switch sweep,
// counting cases/errors and capturing the first failing vector.
module gates_sweep_checker #(
    parameter int unsigned N_CH    = 1,
    parameter int unsigned GRP_W   = 2,
    parameter int unsigned LATENCY = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sw_valid,
    input  logic [2*GRP_W*N_CH-1:0]   sw,
    input  logic [2*N_CH-1:0]         led,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [CNT_W-1:0]          case_cnt,
    output logic [CNT_W-1:0]          err_cnt,
    output logic                      first_err_vld,
    output logic [2*GRP_W*N_CH-1:0]   first_err_sw,
    output logic [CNT_W-1:0]          first_err_case
);

    localparam int unsigned SW_W  = 2 * GRP_W * N_CH;
    localparam int unsigned LED_W = 2 * N_CH;
    localparam int unsigned DRN_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DRN_W-1:0]   r_drn;
    logic [DRN_W-1:0]   w_drn_nxt;

    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [CNT_W-1:0]   r_case;
    logic [CNT_W-1:0]   r_err;
    logic               r_fvld;
    logic [SW_W-1:0]    r_fsw;
    logic [CNT_W-1:0]   r_fcase;

    logic               w_start_go;
    logic               w_push;
    logic               w_last;
    logic               w_cmp_vld;
    logic [SW_W-1:0]    w_cmp_sw;
    logic               w_cmp_en;
    logic               w_mis;
    logic [LED_W-1:0]   w_exp;
    logic [CNT_W-1:0]   w_case_nxt;
    logic [CNT_W-1:0]   w_err_nxt;

    assign w_start_go = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_push     = (r_state == S_RUN) && sw_valid;
    assign w_last     = w_push && (sw == '1);

    // Delay line mirrors the DUT pipeline so led is compared against the sw that produced it
    generate
        if (LATENCY == 0) begin : g_nodly
            assign w_cmp_vld = w_push;
            assign w_cmp_sw  = sw;
        end else begin : g_dly
            logic [LATENCY-1:0] r_dl_vld;
            logic [SW_W-1:0]    r_dl_sw [LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dl_vld <= '0;
                    for (int i = 0; i < int'(LATENCY); i++) begin
                        r_dl_sw[i] <= '0;
                    end
                end else begin
                    r_dl_vld[0] <= w_push;
                    r_dl_sw[0]  <= sw;
                    for (int i = 1; i < int'(LATENCY); i++) begin
                        r_dl_vld[i] <= r_dl_vld[i-1];
                        r_dl_sw[i]  <= r_dl_sw[i-1];
                    end
                    if (w_start_go) begin
                        r_dl_vld <= '0;
                    end
                end
            end

            assign w_cmp_vld = r_dl_vld[LATENCY-1];
            assign w_cmp_sw  = r_dl_sw[LATENCY-1];
        end
    endgenerate

    // Reference gate function: per channel {AND of upper group, OR of lower group}
    always_comb begin
        w_exp = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            w_exp[2*c+1] = &w_cmp_sw[c*2*int'(GRP_W) + int'(GRP_W) +: GRP_W];
            w_exp[2*c]   = |w_cmp_sw[c*2*int'(GRP_W) +: GRP_W];
        end
    end

    assign w_cmp_en = w_cmp_vld && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_mis    = w_cmp_en && (led !== w_exp);

    always_comb begin
        w_case_nxt = r_case;
        w_err_nxt  = r_err;
        if (w_start_go) begin
            w_case_nxt = '0;
            w_err_nxt  = '0;
        end else if (w_cmp_en) begin
            if (r_case != CNT_MAX) begin
                w_case_nxt = r_case + CNT_W'(1);
            end
            if (w_mis && (r_err != CNT_MAX)) begin
                w_err_nxt = r_err + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_drn   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drn   <= w_drn_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drn_nxt   = r_drn;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    if (LATENCY == 0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_drn_nxt   = DRN_W'(LATENCY - 1);
                    end
                end
            end
            S_DRAIN: begin
                if (r_drn == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_drn_nxt = r_drn - DRN_W'(1);
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs follow the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_case  <= '0;
            r_err   <= '0;
            r_fvld  <= 1'b0;
            r_fsw   <= '0;
            r_fcase <= '0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
            r_pass <= (w_state_nxt == S_DONE) && (w_err_nxt == '0);
            r_case <= w_case_nxt;
            r_err  <= w_err_nxt;
            if (w_start_go) begin
                r_fvld  <= 1'b0;
                r_fsw   <= '0;
                r_fcase <= '0;
            end else if (w_mis && !r_fvld) begin
                r_fvld  <= 1'b1;
                r_fsw   <= w_cmp_sw;
                r_fcase <= r_case;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign case_cnt       = r_case;
    assign err_cnt        = r_err;
    assign first_err_vld  = r_fvld;
    assign first_err_sw   = r_fsw;
    assign first_err_case = r_fcase;

endmodule

// File: tb/tb_gates_sweep_checker.sv
// Scoreboard bench for gates_sweep_checker: two checker instances (zero-latency and
// 3-stage pipelined DUT stand-ins) driven with randomized sweeps and injected faults.
module tb_gates_sweep_checker;

    localparam int unsigned A_NCH = 1, A_G = 2, A_LAT = 0, A_CNT = 16;
    localparam int unsigned B_NCH = 2, B_G = 2, B_LAT = 3, B_CNT = 4;
    localparam int unsigned A_SW = 2*A_G*A_NCH, A_LED = 2*A_NCH;
    localparam int unsigned B_SW = 2*B_G*B_NCH, B_LED = 2*B_NCH;

    typedef struct {
        longint unsigned case_n;
        longint unsigned err_n;
        longint unsigned pass;
        longint unsigned fvld;
        longint unsigned fsw;
        longint unsigned fcase;
        longint unsigned done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    longint unsigned cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t a_last, b_last;
    bit a_post = 1'b0;
    bit b_post = 1'b0;

    logic                a_start, a_valid;
    logic [A_SW-1:0]     a_sw;
    logic [A_LED-1:0]    a_led;
    logic                a_busy, a_done, a_pass, a_fvld;
    logic [A_CNT-1:0]    a_case, a_err, a_fcase;
    logic [A_SW-1:0]     a_fsw;
    logic [A_LED-1:0]    a_stuck = '0;
    logic [A_LED-1:0]    a_inv = '0;

    logic                b_start, b_valid;
    logic [B_SW-1:0]     b_sw;
    logic [B_LED-1:0]    b_led;
    logic                b_busy, b_done, b_pass, b_fvld;
    logic [B_CNT-1:0]    b_case, b_err, b_fcase;
    logic [B_SW-1:0]     b_fsw;
    logic [B_LED-1:0]    b_stuck = '0;
    logic [B_LED-1:0]    b_inv = '0;
    logic [B_LED-1:0]    b_pipe [B_LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Golden gate behaviour from plain arithmetic on each channel's field values
    function automatic int unsigned gold(input int unsigned v, input int unsigned nch,
                                         input int unsigned g);
        int unsigned r, lo, hi, full;
        r = 0;
        full = (1 << g) - 1;
        for (int unsigned c = 0; c < nch; c++) begin
            lo = (v >> (c*2*g)) % (1 << g);
            hi = (v >> (c*2*g + g)) % (1 << g);
            if (hi == full) r += (1 << (2*c+1));
            if (lo != 0)    r += (1 << (2*c));
        end
        return r;
    endfunction

    always_comb a_led = (A_LED'(gold(32'(a_sw), A_NCH, A_G)) & ~a_stuck) ^ a_inv;

    always @(posedge clk) begin
        b_pipe[0] <= (B_LED'(gold(32'(b_sw), B_NCH, B_G)) & ~b_stuck) ^ b_inv;
        for (int i = 1; i < int'(B_LAT); i++) b_pipe[i] <= b_pipe[i-1];
    end
    assign b_led = b_pipe[B_LAT-1];

    gates_sweep_checker #(.N_CH(A_NCH), .GRP_W(A_G), .LATENCY(A_LAT), .CNT_W(A_CNT)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .sw_valid(a_valid), .sw(a_sw), .led(a_led),
        .busy(a_busy), .done(a_done), .pass(a_pass), .case_cnt(a_case), .err_cnt(a_err),
        .first_err_vld(a_fvld), .first_err_sw(a_fsw), .first_err_case(a_fcase)
    );

    gates_sweep_checker #(.N_CH(B_NCH), .GRP_W(B_G), .LATENCY(B_LAT), .CNT_W(B_CNT)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .sw_valid(b_valid), .sw(b_sw), .led(b_led),
        .busy(b_busy), .done(b_done), .pass(b_pass), .case_cnt(b_case), .err_cnt(b_err),
        .first_err_vld(b_fvld), .first_err_sw(b_fsw), .first_err_case(b_fcase)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input longint unsigned c,
                              input longint unsigned er, input longint unsigned p,
                              input longint unsigned fv, input longint unsigned fs,
                              input longint unsigned fc, input longint unsigned bz);
        chk({tag, "_case_cnt"}, c, e.case_n);
        chk({tag, "_err_cnt"}, er, e.err_n);
        chk({tag, "_pass"}, p, e.pass);
        chk({tag, "_first_err_vld"}, fv, e.fvld);
        chk({tag, "_first_err_sw"}, fs, e.fsw);
        chk({tag, "_first_err_case"}, fc, e.fcase);
        chk({tag, "_done_cycle"}, cyc, e.done_cyc);
        chk({tag, "_busy_in_done"}, bz, 0);
    endtask

    // Monitors: pop the expected verdict whenever a done pulse appears, then check the hold cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_post) begin
                chk("a_done_one_cycle", 64'(a_done), 0);
                chk("a_pass_held", 64'(a_pass), a_last.pass);
                chk("a_err_held", 64'(a_err), a_last.err_n);
                a_post = 1'b0;
            end else if (a_done) begin
                if (qa.size() == 0) chk("a_unexpected_done", 64'(a_done), 0);
                else begin
                    a_last = qa.pop_front();
                    check_done("a", a_last, 64'(a_case), 64'(a_err), 64'(a_pass), 64'(a_fvld),
                               64'(a_fsw), 64'(a_fcase), 64'(a_busy));
                    a_post = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_post) begin
                chk("b_done_one_cycle", 64'(b_done), 0);
                chk("b_pass_held", 64'(b_pass), b_last.pass);
                chk("b_err_held", 64'(b_err), b_last.err_n);
                b_post = 1'b0;
            end else if (b_done) begin
                if (qb.size() == 0) chk("b_unexpected_done", 64'(b_done), 0);
                else begin
                    b_last = qb.pop_front();
                    check_done("b", b_last, 64'(b_case), 64'(b_err), 64'(b_pass), 64'(b_fvld),
                               64'(b_fsw), 64'(b_fcase), 64'(b_busy));
                    b_post = 1'b1;
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_busy"}, 64'(a_busy), 0);
        chk({tag, "_a_done"}, 64'(a_done), 0);
        chk({tag, "_a_pass"}, 64'(a_pass), 0);
        chk({tag, "_a_case"}, 64'(a_case), 0);
        chk({tag, "_a_err"}, 64'(a_err), 0);
        chk({tag, "_a_fvld"}, 64'(a_fvld), 0);
        chk({tag, "_a_fsw"}, 64'(a_fsw), 0);
        chk({tag, "_a_fcase"}, 64'(a_fcase), 0);
        chk({tag, "_b_busy"}, 64'(b_busy), 0);
        chk({tag, "_b_pass"}, 64'(b_pass), 0);
        chk({tag, "_b_case"}, 64'(b_case), 0);
        chk({tag, "_b_err"}, 64'(b_err), 0);
        chk({tag, "_b_fvld"}, 64'(b_fvld), 0);
        chk({tag, "_b_fsw"}, 64'(b_fsw), 0);
        chk({tag, "_b_fcase"}, 64'(b_fcase), 0);
    endtask

    task automatic drive(input bit inst, input bit st, input bit vl, input int unsigned v);
        @(posedge clk);
        #1;
        if (inst) begin
            b_start = st; b_valid = vl; b_sw = B_SW'(v);
        end else begin
            a_start = st; a_valid = vl; a_sw = A_SW'(v);
        end
    endtask

    // One sweep: vecs must end with the all-ones vector; noise adds gaps, ignored starts and late pushes
    task automatic run_sweep(input bit inst, input int unsigned vecs[$], input int unsigned stuck,
                             input int unsigned inv, input bit noise);
        exp_t e;
        int unsigned nch, g, lat, cntw, nled, all1, sat, g0, f0, errs, gaps;
        int first;
        nch  = inst ? B_NCH : A_NCH;
        g    = inst ? B_G : A_G;
        lat  = inst ? B_LAT : A_LAT;
        cntw = inst ? B_CNT : A_CNT;
        nled = inst ? B_LED : A_LED;
        all1 = (1 << (2*g*nch)) - 1;
        sat  = (1 << cntw) - 1;
        if (inst) begin b_stuck = B_LED'(stuck); b_inv = B_LED'(inv); end
        else      begin a_stuck = A_LED'(stuck); a_inv = A_LED'(inv); end
        errs = 0;
        first = -1;
        e.fsw = 0;
        foreach (vecs[i]) begin
            g0 = gold(vecs[i], nch, g);
            f0 = ((g0 & ~stuck) ^ inv) & ((1 << nled) - 1);
            if (f0 != g0) begin
                if (first < 0) begin first = i; e.fsw = vecs[i]; end
                errs++;
            end
        end
        e.case_n = (vecs.size() > sat) ? sat : vecs.size();
        e.err_n  = (errs > sat) ? sat : errs;
        e.pass   = (errs == 0) ? 1 : 0;
        e.fvld   = (first >= 0) ? 1 : 0;
        e.fcase  = (first < 0) ? 0 : ((first > int'(sat)) ? sat : longint'(first));
        drive(inst, 1'b1, noise ? 1'($urandom % 2) : 1'b0, $urandom & all1);
        foreach (vecs[i]) begin
            gaps = noise ? ($urandom % 3) : 0;
            for (int k = 0; k < int'(gaps); k++)
                drive(inst, noise && (($urandom % 6) == 0), 1'b0, $urandom & all1);
            drive(inst, 1'b0, 1'b1, vecs[i]);
        end
        e.done_cyc = cyc + lat + 1;
        if (inst) qb.push_back(e); else qa.push_back(e);
        for (int k = 0; k < int'(lat) + 3; k++)
            drive(inst, 1'b0, noise ? 1'($urandom % 2) : 1'b0, $urandom & all1);
        drive(inst, 1'b0, 1'b0, 0);
        for (int k = 0; k < 40 && (inst ? qb.size() : qa.size()) != 0; k++) @(posedge clk);
        if (inst) begin
            if (qb.size() != 0) begin chk("b_done_timeout", qb.size(), 0); qb.delete(); end
        end else begin
            if (qa.size() != 0) begin chk("a_done_timeout", qa.size(), 0); qa.delete(); end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic rand_vecs(input int unsigned n, input int unsigned all1, output int unsigned q[$]);
        int unsigned v;
        q.delete();
        for (int i = 0; i < int'(n); i++) begin
            v = $urandom & all1;
            if (v == all1) v = 0;
            q.push_back(v);
        end
        q.push_back(all1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned vq[$];
        a_start = 0; a_valid = 0; a_sw = '0;
        b_start = 0; b_valid = 0; b_sw = '0;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        vq.delete();
        for (int unsigned v = 0; v < 16; v++) vq.push_back(v);
        run_sweep(1'b0, vq, 0, 0, 1'b0);
        run_sweep(1'b0, vq, 32'h2, 0, 1'b0);

        vq.delete();
        for (int unsigned v = 0; v < 256; v++) vq.push_back(v);
        run_sweep(1'b1, vq, 0, 0, 1'b1);
        run_sweep(1'b1, vq, 0, 32'hF, 1'b1);
        run_sweep(1'b1, vq, 0, 32'h1, 1'b1);

        for (int r = 0; r < 5; r++) begin
            rand_vecs($urandom_range(30, 3), 15, vq);
            run_sweep(1'b0, vq, ($urandom % 2) ? ($urandom % 4) : 0, ($urandom % 3 == 0) ? ($urandom % 4) : 0, 1'b1);
            rand_vecs($urandom_range(30, 3), 255, vq);
            run_sweep(1'b1, vq, ($urandom % 2) ? ($urandom % 16) : 0, ($urandom % 3 == 0) ? ($urandom % 16) : 0, 1'b1);
        end

        // Abort mid-sweep: outputs clear at once and no done follows
        drive(1'b0, 1'b1, 1'b0, 0);
        for (int unsigned v = 0; v < 7; v++) drive(1'b0, 1'b0, 1'b1, v);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        a_valid = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        vq.delete();
        for (int unsigned v = 0; v < 16; v++) vq.push_back(v);
        run_sweep(1'b0, vq, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
